regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with an integrated scoreboard, the next-generation replacement for the fixed 32×64 two-read/one-write file in the decode stage. It adds configurable width, depth and read-port count, a hardwired zero register, and write-to-read bypass so decode sees same-cycle writeback data. It also adds per-register pending bits set at issue and cleared at writeback, so the hazard unit can stall on true RAW dependences. Unlike the previous file, it has an asynchronous reset that clears all state.

## Interface
- WIDTH, 64, data width per register
- NREGS, 32, register count; power of two, ≥ 2; AW = log2(NREGS)
- NRD, 2, number of read ports, ≥ 1
- ZERO_REG, 31, index of the hardwired-zero register
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears every register and pending bit
- rd_addr  in  NRD*AW  read addresses; port p at [p*AW +: AW]
- rd_data  out  NRD*WIDTH  read data; port p at [p*WIDTH +: WIDTH]
- rd_ready  out  NRD  port p's register has no pending write (or is bypassed)
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  WIDTH  writeback value
- iss_en  in  1  issue strobe; marks iss_addr pending
- iss_addr  in  AW  destination of the issuing instruction
- flush  in  1  clears all pending bits (pipeline squash)
- pend_cnt  out  AW+1  number of registers currently pending

## Operation
- State: NREGS-1 storage registers of WIDTH bits, plus NREGS-1 pending bits. ZERO_REG has neither.
- Read, per port, combinational:
  - rd_addr==ZERO_REG → rd_data=0, rd_ready=1.
  - else if wr_en && wr_addr==rd_addr → rd_data=wr_data, rd_ready=1 (bypass).
  - else → rd_data=stored value, rd_ready=!pending[rd_addr].
- Write: on the clock edge with wr_en and wr_addr≠ZERO_REG, the register takes wr_data. Writes to ZERO_REG are dropped with no side effects.
- Pending-bit update per register r, in priority order:
  - flush → 0
  - iss_en && iss_addr==r → 1 (issue wins over a same-cycle writeback to r: the new producer supersedes)
  - wr_en && wr_addr==r → 0
  - else hold
- Issue to ZERO_REG is ignored.
- flush does not block a same-cycle write: data still updates and pending ends at 0.
- pend_cnt is the population count of the pending bits.
  - Registered: updated at the same edge as the bits, so it always equals the popcount of the current bits.
  - Width AW+1; the maximum value is NREGS-1 and never wraps.
- Redundant events are legal and idempotent:
  - issue to an already-pending register leaves it 1;
  - writeback to a non-pending register clears nothing and does not decrement pend_cnt.
- Multiple read ports may address the same register; each resolves independently.

## Timing
- Reads and bypass: zero-cycle (combinational) from rd_addr, wr_en, wr_addr, wr_data.
- Write data is visible through storage from the cycle after the edge; bypass covers the write cycle itself.
- Pending set by issue at edge N: rd_ready for that register is 0 from cycle N+1 until writeback. In the writeback cycle it reads 1 via bypass; it reads 1 from storage afterwards.
- pend_cnt: 1-cycle latency from iss_en, wr_en and flush.
- Reset, asserted at any time, including mid-cycle with strobes active:
  - immediately, all storage=0, pending=0, pend_cnt=0;
  - rd_data=0 and rd_ready=1 for every address, except a live bypass, which still forwards wr_data combinationally;
  - strobes are ignored while reset is high;
  - first update occurs at the first rising edge after deassertion.

## Test plan
- Reset, then read all 32 addresses on both ports → every rd_data=0, rd_ready=1, pend_cnt=0.
- Write 64'hDEAD_BEEF_0123_4567 to r5 with rd_addr0=5 in the same cycle → rd_data0 shows the value in that cycle (bypass) and in the next cycle (storage). Write 64'hFFFF… to r31 → reads of r31 stay 0.
- Issue r7, then r9 → pend_cnt 1 then 2, rd_ready low for 7 and 9. Writeback r7 → bypass ready in that cycle, pend_cnt=1 next cycle.
- Same cycle iss_addr=3 and wr_addr=3 on a pending r3 → r3 data updated, r3 still pending, pend_cnt unchanged.
- Issue r1, r2, r4, then flush together with iss_en r6 and a write to r2 → pend_cnt=0, r6 not pending, r2 holds the new data.
- Assert reset asynchronously between edges after several writes and issues → outputs clear before the next edge; a write presented at deassertion takes effect at the first edge after.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: groups the read, writeback, issue and flush signals of
// regfile_sb, including its read data, ready and pending-count outputs.
//   master : drives addresses and strobes; receives rd_data, rd_ready, pend_cnt
//   slave  : the register file itself
// Parameters must match the regfile_sb instance attached to it.
interface regfile_sb_if #(
    parameter int WIDTH = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_ready;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic                 flush;
    logic [AW:0]          pend_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_ready, pend_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_ready, pend_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with per-register pending
// (scoreboard) bits, a hardwired-zero register and write-to-read bypass.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high; clears all data, pending bits, count
//   rf    : regfile_sb_if slave -- NRD combinational read ports with
//           ready flags, one writeback port, one issue port, flush,
//           and a registered count of pending registers.
module regfile_sb #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 31
) (
    input  logic        clk,
    input  logic        reset,
    regfile_sb_if.slave rf
);
    localparam int            AW        = $clog2(NREGS);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [WIDTH-1:0] data_q [NREGS];
    logic [WIDTH-1:0] data_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [AW:0]      pend_cnt_q;
    logic [AW:0]      pend_cnt_d;

    logic [AW-1:0]        rd_idx_s [NRD];
    logic [NRD*WIDTH-1:0] rd_data_s;
    logic [NRD-1:0]       rd_ready_s;

    function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Next-state data and pending bits; the zero register never holds state.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            if (AW'(r) == ZERO_ADDR) begin
                data_d[r] = '0;
                pend_d[r] = 1'b0;
            end else begin
                if (rf.wr_en && (rf.wr_addr == AW'(r))) begin
                    data_d[r] = rf.wr_data;
                end else begin
                    data_d[r] = data_q[r];
                end
                // Issue outranks writeback: the new producer supersedes the old one.
                if (rf.flush) begin
                    pend_d[r] = 1'b0;
                end else if (rf.iss_en && (rf.iss_addr == AW'(r))) begin
                    pend_d[r] = 1'b1;
                end else if (rf.wr_en && (rf.wr_addr == AW'(r))) begin
                    pend_d[r] = 1'b0;
                end else begin
                    pend_d[r] = pend_q[r];
                end
            end
        end
        // Counting the next bits keeps the registered count aligned with them.
        pend_cnt_d = popcount(pend_d);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                data_q[r] <= data_d[r];
            end
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Combinational read ports: zero register, then bypass, then storage.
    always_comb begin
        rd_data_s  = '0;
        rd_ready_s = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_idx_s[p] = rf.rd_addr[p*AW +: AW];
            if (rd_idx_s[p] == ZERO_ADDR) begin
                rd_data_s[p*WIDTH +: WIDTH] = '0;
                rd_ready_s[p]               = 1'b1;
            end else if (rf.wr_en && (rf.wr_addr == rd_idx_s[p])) begin
                rd_data_s[p*WIDTH +: WIDTH] = rf.wr_data;
                rd_ready_s[p]               = 1'b1;
            end else begin
                rd_data_s[p*WIDTH +: WIDTH] = data_q[rd_idx_s[p]];
                rd_ready_s[p]               = ~pend_q[rd_idx_s[p]];
            end
        end
    end

    assign rf.rd_data  = rd_data_s;
    assign rf.rd_ready = rd_ready_s;
    assign rf.pend_cnt = pend_cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed vectors with literal expectations, plus
// a behavioural array model compared against the DUT on every falling edge.
module tb_regfile_sb;
    localparam int WIDTH = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int ZR    = 31;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    bit   chk_on;

    regfile_sb_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(ZR)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: register contents and pending flags as plain arrays.
    logic [63:0] m_data [32];
    logic        m_pend [32];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] <= 64'd0;
                m_pend[i] <= 1'b0;
            end
        end else begin
            if (bus.wr_en && bus.wr_addr != 5'd31) m_data[bus.wr_addr] <= bus.wr_data;
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
            end else begin
                if (bus.wr_en) m_pend[bus.wr_addr] <= 1'b0;
                // Issue is assigned last so it wins a same-register collision.
                if (bus.iss_en && bus.iss_addr != 5'd31) m_pend[bus.iss_addr] <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) if (m_pend[i]) c++;
        return c;
    endfunction

    // Compare process: DUT outputs versus the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int p = 0; p < NRD; p++) begin
                logic [4:0]  a;
                logic [63:0] ed;
                logic        er;
                a = bus.rd_addr[p*5 +: 5];
                if (a == 5'd31) begin
                    ed = 64'd0; er = 1'b1;
                end else if (bus.wr_en && bus.wr_addr == a) begin
                    ed = bus.wr_data; er = 1'b1;
                end else begin
                    ed = m_data[a]; er = ~m_pend[a];
                end
                check($sformatf("model_rd_data%0d", p), bus.rd_data[p*64 +: 64], ed);
                check($sformatf("model_rd_ready%0d", p), {63'd0, bus.rd_ready[p]}, {63'd0, er});
            end
            check("model_pend_cnt", {58'd0, bus.pend_cnt}, 64'(model_count()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en  = 1'b0;
        bus.iss_en = 1'b0;
        bus.flush  = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; chk_on = 1'b0;
        reset = 1'b1;
        idle();
        bus.wr_addr = 5'd0; bus.wr_data = 64'd0; bus.iss_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        tick(); tick();
        reset  = 1'b0;
        chk_on = 1'b1;

        // Post-reset: every address reads zero and ready.
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            @(negedge clk);
            check("reset_rd_data", bus.rd_data[63:0] | bus.rd_data[127:64], 64'd0);
            check("reset_rd_ready", {62'd0, bus.rd_ready}, 64'd3);
            tick();
        end
        check("reset_pend_cnt", {58'd0, bus.pend_cnt}, 64'd0);

        // Write r5 with bypass in the write cycle, storage the next.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 64'hDEAD_BEEF_0123_4567;
        set_rd(5'd5, 5'd0);
        @(negedge clk);
        check("bypass_r5", bus.rd_data[63:0], 64'hDEAD_BEEF_0123_4567);
        tick(); idle();
        @(negedge clk);
        check("stored_r5", bus.rd_data[63:0], 64'hDEAD_BEEF_0123_4567);

        // Writes to the zero register are dropped, even during the write cycle.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        set_rd(5'd31, 5'd31);
        @(negedge clk);
        check("r31_write_cycle", bus.rd_data[63:0], 64'd0);
        tick(); idle();
        @(negedge clk);
        check("r31_after", bus.rd_data[127:64], 64'd0);

        // Issue r7 then r9.
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        tick();
        bus.iss_addr = 5'd9;
        @(negedge clk);
        check("pend_cnt_1", {58'd0, bus.pend_cnt}, 64'd1);
        tick(); idle();
        set_rd(5'd7, 5'd9);
        @(negedge clk);
        check("pend_cnt_2", {58'd0, bus.pend_cnt}, 64'd2);
        check("ready_7_9_low", {62'd0, bus.rd_ready}, 64'd0);

        // Writeback r7: ready through bypass now, count drops next cycle.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h0000_0000_0000_0777;
        @(negedge clk);
        check("wb7_bypass_ready", {62'd0, bus.rd_ready}, 64'd1);
        check("wb7_bypass_data", bus.rd_data[63:0], 64'h777);
        tick(); idle();
        @(negedge clk);
        check("wb7_pend_cnt", {58'd0, bus.pend_cnt}, 64'd1);
        check("wb7_ready", {62'd0, bus.rd_ready}, 64'd1);

        // Same-cycle issue and writeback on a pending r3.
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        tick(); idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'h3333_0000_3333_0000;
        tick(); idle();
        set_rd(5'd3, 5'd9);
        @(negedge clk);
        check("r3_data", bus.rd_data[63:0], 64'h3333_0000_3333_0000);
        check("r3_pending", {62'd0, bus.rd_ready}, 64'd0);
        check("r3_pend_cnt", {58'd0, bus.pend_cnt}, 64'd2);

        // Issue r1, r2, r4, then flush with issue r6 and a write to r2.
        bus.iss_en = 1'b1;
        bus.iss_addr = 5'd1; tick();
        bus.iss_addr = 5'd2; tick();
        bus.iss_addr = 5'd4; tick();
        idle();
        @(negedge clk);
        check("pre_flush_cnt", {58'd0, bus.pend_cnt}, 64'd5);
        bus.flush = 1'b1; bus.iss_en = 1'b1; bus.iss_addr = 5'd6;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 64'h2222_2222_2222_2222;
        tick(); idle();
        set_rd(5'd6, 5'd2);
        @(negedge clk);
        check("flush_cnt", {58'd0, bus.pend_cnt}, 64'd0);
        check("flush_ready", {62'd0, bus.rd_ready}, 64'd3);
        check("flush_r2_data", bus.rd_data[127:64], 64'h2222_2222_2222_2222);

        // Short pseudo-random stretch, checked by the model only.
        for (int i = 0; i < 60; i++) begin
            bus.wr_en    = ($urandom_range(0, 2) != 0);
            bus.wr_addr  = 5'($urandom_range(0, 31));
            bus.wr_data  = {$urandom, $urandom};
            bus.iss_en   = ($urandom_range(0, 1) != 0);
            bus.iss_addr = 5'($urandom_range(0, 31));
            bus.flush    = ($urandom_range(0, 15) == 0);
            set_rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            tick();
        end
        idle();

        // Asynchronous reset between edges with strobes active.
        bus.iss_en = 1'b1; bus.iss_addr = 5'd10;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd11; bus.wr_data = 64'h1111_1111_1111_1111;
        tick();
        bus.wr_addr = 5'd12; bus.wr_data = 64'hC0DE_C0DE_C0DE_C0DE;
        bus.iss_addr = 5'd13;
        set_rd(5'd12, 5'd11);
        #2;
        reset = 1'b1;
        #1;
        check("arst_bypass", bus.rd_data[63:0], 64'hC0DE_C0DE_C0DE_C0DE);
        check("arst_r11_clear", bus.rd_data[127:64], 64'd0);
        check("arst_pend_cnt", {58'd0, bus.pend_cnt}, 64'd0);
        check("arst_ready", {62'd0, bus.rd_ready}, 64'd3);
        tick();
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("arst_held_r12", bus.rd_data[63:0], 64'd0);
        bus.wr_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(); idle();
        @(negedge clk);
        check("post_rst_write", bus.rd_data[63:0], 64'hC0DE_C0DE_C0DE_C0DE);
        check("post_rst_cnt", {58'd0, bus.pend_cnt}, 64'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
